// File: rtl/parser_pkg.sv
// Shared types and constants for the byte-stream frame parser.
package parser_pkg;

  // Parser states: hunting for sync, then length, payload, checksum, and
  // finally holding a good frame until the consumer releases it.
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Start-of-frame marker, only meaningful while hunting.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Error causes reported on o_err_code.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store: DEPTH x 8, synchronous write, asynchronous read so the
// consumer sees the byte at its address in the same cycle.
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH];

  // Write port: one byte per enabled cycle; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/packet_parser.sv
// Frame parser: pops bytes from an upstream FIFO, recognises
// SYNC / LEN / payload / CHK frames, buffers the payload and holds a
// checksum-good frame until acknowledged. Bad length, bad checksum and
// inter-byte timeout abort the frame and are reported on the error outputs.
module packet_parser
  import parser_pkg::*;
#(
  parameter  int MAX_LEN     = 16,
  parameter  int TIMEOUT_CYC = 1_000_000,
  localparam int AW          = $clog2(MAX_LEN),
  localparam int LW          = AW + 1,
  localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ready,
  input  logic [7:0]    i_D,
  output logic          o_read,
  output logic          o_frame_valid,
  input  logic          i_frame_ack,
  output logic [LW-1:0] o_len,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  output logic [7:0]    o_err_cnt
);

  state_e        state_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    chk_q;
  logic [TW-1:0] tmo_q;
  logic          frame_valid_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [7:0]    err_cnt_q;

  logic          take;
  logic          active;
  logic          tmo_hit;
  logic          bad_len;
  logic          last_byte;
  logic          buf_we;
  logic          err_hit_d;
  logic [1:0]    err_code_d;

  // A byte is consumed exactly when we pop it; DONE backpressures upstream.
  assign o_read    = i_ready && (state_q != DONE);
  assign take      = o_read;

  // Timeout only runs while a frame is in flight; an arriving byte wins.
  assign active    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign tmo_hit   = active && !take && (tmo_q == TW'(TIMEOUT_CYC - 1));

  assign bad_len   = (i_D == 8'd0) || ({1'b0, i_D} > 9'(MAX_LEN));
  assign last_byte = ({1'b0, idx_q} == (len_q - LW'(1)));

  // Payload bytes go straight into the buffer at the running index.
  assign buf_we    = take && (state_q == PAYLOAD);

  // Classify this cycle's frame error, if any.
  always_comb begin
    err_hit_d  = 1'b0;
    err_code_d = ERR_NONE;
    if (tmo_hit) begin
      err_hit_d  = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else if (take && (state_q == LEN) && bad_len) begin
      err_hit_d  = 1'b1;
      err_code_d = ERR_BAD_LEN;
    end else if (take && (state_q == CHK) && (i_D != chk_q)) begin
      err_hit_d  = 1'b1;
      err_code_d = ERR_CHECKSUM;
    end
  end

  // Frame FSM with its datapath registers and the frame-valid flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= HUNT;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (take && (i_D == SYNC_BYTE)) begin
            state_q <= LEN;
          end
        end
        LEN: begin
          if (take) begin
            if (bad_len) begin
              state_q <= HUNT;
            end else begin
              len_q   <= LW'(i_D);
              chk_q   <= i_D;
              idx_q   <= '0;
              state_q <= PAYLOAD;
            end
          end else if (tmo_hit) begin
            state_q <= HUNT;
          end
        end
        PAYLOAD: begin
          if (take) begin
            chk_q <= chk_q ^ i_D;
            idx_q <= idx_q + AW'(1);
            if (last_byte) begin
              state_q <= CHK;
            end
          end else if (tmo_hit) begin
            state_q <= HUNT;
          end
        end
        CHK: begin
          if (take) begin
            if (i_D == chk_q) begin
              state_q       <= DONE;
              frame_valid_q <= 1'b1;
            end else begin
              state_q <= HUNT;
            end
          end else if (tmo_hit) begin
            state_q <= HUNT;
          end
        end
        DONE: begin
          if (i_frame_ack) begin
            state_q       <= HUNT;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= HUNT;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Idle-cycle counter: cleared by every consumed byte and outside a frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmo_q <= '0;
    end else if (!active || take || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Error reporting: one-cycle pulse, sticky cause, saturating count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_cnt_q  <= '0;
    end else begin
      err_q <= err_hit_d;
      if (err_hit_d) begin
        err_code_q <= err_code_d;
        err_cnt_q  <= sat_inc8(err_cnt_q);
      end
    end
  end

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_frame_buf (
    .i_clk   (i_clk),
    .i_we    (buf_we),
    .i_waddr (idx_q),
    .i_wdata (i_D),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_frame_valid = frame_valid_q;
  assign o_len         = len_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_packet_parser.sv
// Bench for packet_parser: an upstream byte FIFO modelled as a queue, a
// whole-stream reference parser producing expected frames and error codes,
// and a monitor that checks every delivered frame and error pulse.
module tb_packet_parser;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 40;
  localparam int AW          = $clog2(MAX_LEN);
  localparam int LW          = AW + 1;

  logic          i_clk       = 1'b0;
  logic          i_rst       = 1'b0;
  logic          i_ready     = 1'b0;
  logic [7:0]    i_D         = 8'h00;
  logic          i_frame_ack = 1'b0;
  logic [AW-1:0] i_rd_addr   = '0;
  logic          o_read;
  logic          o_frame_valid;
  logic [LW-1:0] o_len;
  logic [7:0]    o_rd_data;
  logic          o_err;
  logic [1:0]    o_err_code;
  logic [7:0]    o_err_cnt;

  packet_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ready       (i_ready),
    .i_D           (i_D),
    .o_read        (o_read),
    .o_frame_valid (o_frame_valid),
    .i_frame_ack   (i_frame_ack),
    .o_len         (o_len),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_err         (o_err),
    .o_err_code    (o_err_code),
    .o_err_cnt     (o_err_cnt)
  );

  always #50 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] up_q[$];
  int         exp_len_q[$];
  logic [7:0] exp_data_q[$];
  int         exp_err_q[$];
  int         exp_cnt    = 0;
  int         err_pulses = 0;
  int         frames_seen = 0;
  int         stall_pct  = 0;
  int         ack_min    = 0;
  int         ack_max    = 2;
  bit         fv_pending = 1'b0;
  bit         acked      = 1'b0;
  int         ack_wait   = 0;
  int         hold_size  = 0;
  int         cur_len    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  // Reference parser over a complete byte stream: scan for sync, apply the
  // length rule, then compare the XOR of LEN and payload with the CHK byte.
  function automatic void model(input logic [7:0] s[$]);
    int         i;
    int         len;
    logic [7:0] x;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= s.size()) break;
      len = int'(s[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        exp_err_q.push_back(1);
        i += 2;
        continue;
      end
      if (i + 2 + len >= s.size()) break;
      x = s[i+1];
      for (int k = 0; k < len; k++) x = x ^ s[i+2+k];
      if (x == s[i+2+len]) begin
        exp_len_q.push_back(len);
        for (int k = 0; k < len; k++) exp_data_q.push_back(s[i+2+k]);
      end else begin
        exp_err_q.push_back(2);
      end
      i += len + 3;
    end
  endfunction

  task automatic verify_frame();
    int         len;
    logic [7:0] b;
    frames_seen++;
    if (exp_len_q.size() == 0) begin
      check("frame_unexpected", 32'(o_frame_valid), 0);
      return;
    end
    len     = exp_len_q.pop_front();
    cur_len = len;
    check("frame_len", 32'(o_len), len);
    for (int k = 0; k < len; k++) begin
      i_rd_addr = AW'(k);
      #1;
      b = exp_data_q.pop_front();
      check("payload", 32'(o_rd_data), 32'(b));
    end
    $display("frame %0d: len=%0d read back", frames_seen, len);
  endtask

  task automatic monitor();
    int code;
    if (o_err) begin
      err_pulses++;
      if (exp_cnt < 255) exp_cnt++;
      if (exp_err_q.size() == 0) begin
        check("err_unexpected", 32'(o_err), 0);
      end else begin
        code = exp_err_q.pop_front();
        check("err_code", 32'(o_err_code), code);
      end
      check("err_cnt", 32'(o_err_cnt), exp_cnt);
      $display("error pulse: code=%0d count=%0d", o_err_code, o_err_cnt);
    end
    if (o_frame_valid) begin
      if (!fv_pending) begin
        fv_pending = 1'b1;
        acked      = 1'b0;
        hold_size  = up_q.size();
        verify_frame();
        ack_wait   = $urandom_range(ack_min, ack_max);
      end
      if (!acked) begin
        if (ack_wait == 0) begin
          check("bp_hold", up_q.size(), hold_size);
          check("len_hold", 32'(o_len), cur_len);
          i_frame_ack = 1'b1;
          acked       = 1'b1;
        end else begin
          ack_wait--;
        end
      end
    end else begin
      fv_pending = 1'b0;
    end
  endtask

  // One clock: present FIFO head, pop on o_read, then observe outputs.
  task automatic tick();
    logic rd;
    i_ready = (up_q.size() != 0) && ($urandom_range(0, 99) >= stall_pct);
    i_D     = (up_q.size() != 0) ? up_q[0] : 8'h00;
    #1;
    if (!i_ready) check("read_gated", 32'(o_read), 0);
    else if (fv_pending) check("read_in_done", 32'(o_read), 0);
    rd = o_read;
    @(posedge i_clk);
    if (rd && up_q.size() != 0) void'(up_q.pop_front());
    #1;
    i_frame_ack = 1'b0;
    monitor();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((up_q.size() != 0 || fv_pending) && guard < 5000) begin
      tick();
      guard++;
    end
    check("drain_done", up_q.size() + int'(fv_pending), 0);
  endtask

  task automatic leftovers();
    check("frames_left", exp_len_q.size(), 0);
    check("errors_left", exp_err_q.size(), 0);
  endtask

  task automatic run_stream(input logic [7:0] s[$]);
    model(s);
    foreach (s[k]) up_q.push_back(s[k]);
    drain();
    repeat (2) tick();
    leftovers();
  endtask

  task automatic check_reset_values();
    check("rst_valid", 32'(o_frame_valid), 0);
    check("rst_len", 32'(o_len), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_code", 32'(o_err_code), 0);
    check("rst_cnt", 32'(o_err_cnt), 0);
  endtask

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] b;
    logic [7:0] x;
    int         n0;
    int         kind;
    int         len;

    // Power-on reset: outputs idle, o_read follows i_ready in HUNT.
    i_rst = 1'b0;
    #120;
    check_reset_values();
    i_ready = 1'b1;
    #1;
    check("rst_read", 32'(o_read), 1);
    i_ready = 1'b0;
    #10;
    i_rst = 1'b1;

    // Frame 11 22 33; the trailing byte is the XOR of LEN and payload (03),
    // so the 00-terminated variant is a checksum failure.
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_stream(s);
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    run_stream(s);

    // Checksum error followed by a good frame.
    s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    run_stream(s);

    // Garbage, zero length, over-length.
    s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11};
    run_stream(s);

    // Sync bytes inside a frame are data; maximum length frame.
    s = '{8'hA5, 8'h03, 8'hA5, 8'hA5, 8'h01, 8'h02};
    run_stream(s);
    s = '{8'hA5, 8'h10};
    x = 8'h10;
    for (int k = 0; k < MAX_LEN; k++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      s.push_back(b);
    end
    s.push_back(x);
    run_stream(s);

    // Timeout: one idle cycle short of the limit is tolerated.
    s = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
    model(s);
    up_q = '{8'hA5, 8'h02, 8'hAA};
    drain();
    n0 = err_pulses;
    repeat (TIMEOUT_CYC - 1) tick();
    check("tmo_early", err_pulses, n0);
    up_q.push_back(8'hBB);
    up_q.push_back(8'h13);
    drain();
    repeat (2) tick();
    leftovers();

    // Timeout: exactly TIMEOUT_CYC idle cycles aborts with code 3.
    up_q = '{8'hA5, 8'h02, 8'hAA};
    drain();
    n0 = err_pulses;
    repeat (TIMEOUT_CYC - 1) tick();
    check("tmo_before", err_pulses, n0);
    exp_err_q.push_back(3);
    tick();
    check("tmo_at", err_pulses, n0 + 1);
    s = '{8'hBB, 8'hA5, 8'h01, 8'h44, 8'h45};
    run_stream(s);

    // Two frames queued while the first is held: upstream must not drain.
    ack_min = 12;
    ack_max = 12;
    s = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01, 8'hA5, 8'h03, 8'h07, 8'h08, 8'h09, 8'h05};
    run_stream(s);
    ack_min = 0;
    ack_max = 3;

    // Randomised mix of garbage, good, bad-checksum and bad-length frames.
    stall_pct = 30;
    s.delete();
    for (int u = 0; u < 30; u++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          repeat ($urandom_range(1, 3)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            s.push_back(b);
          end
        end
        3: begin
          s.push_back(8'hA5);
          if ($urandom_range(0, 1) == 1) s.push_back(8'h00);
          else s.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        end
        default: begin
          len = $urandom_range(1, MAX_LEN);
          s.push_back(8'hA5);
          s.push_back(8'(len));
          x = 8'(len);
          for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            x = x ^ b;
            s.push_back(b);
          end
          if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
          s.push_back(x);
        end
      endcase
    end
    run_stream(s);
    stall_pct = 0;

    // Reset in the middle of a payload discards the partial frame.
    up_q = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03};
    drain();
    #10;
    i_rst = 1'b0;
    #1;
    check_reset_values();
    up_q.delete();
    exp_cnt    = 0;
    fv_pending = 1'b0;
    acked      = 1'b0;
    #20;
    i_rst = 1'b1;
    s = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    run_stream(s);

    // Error counter saturates at 255.
    s.delete();
    repeat (260) begin
      s.push_back(8'hA5);
      s.push_back(8'h00);
    end
    run_stream(s);
    check("err_sat", 32'(o_err_cnt), 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
